// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the register-file writeback arbiter:
//   - default datapath / register-address widths
//   - source codes used on the writeback mux select (wb_sel)
//   - default starvation-guard limit for pending ALU results
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam int WB_DATA_W   = 32;
   localparam int WB_REG_AW   = 5;
   localparam int WB_MAX_WAIT = 4;

   // Writeback mux select: 0 routes data1 (ALU), 1 routes data2 (load).
   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LD  = 1'b1
   } wb_src_e;

endpackage : wb_pkg

// File: rtl/wb_hold_slot.sv
// -----------------------------------------------------------------------------
// wb_hold_slot
// One-entry valid/ready holding register for a writeback source.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake; transfer when both are high
//   in_data, in_rd    payload captured on transfer
//   pop               arbiter grant: the held item leaves this cycle
//   full              slot holds an item
//   data, rd          held payload (meaningful only while full)
// -----------------------------------------------------------------------------
module wb_hold_slot
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int REG_AW = WB_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              pop,
   output logic              full,
   output logic [DATA_W-1:0] data,
   output logic [REG_AW-1:0] rd
);

   logic              full_q, full_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [REG_AW-1:0] rd_q,   rd_d;
   logic              push;

   // Ready while empty, or while the current item is leaving so a new one can
   // enter on the same edge. Held low during reset.
   assign in_ready = !rst && (!full_q || pop);
   assign push     = in_valid && in_ready;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the if-chain leaves it unassigned (no latch).
      full_d = full_q;
      data_d = data_q;
      rd_d   = rd_q;
      if (push) begin
         full_d = 1'b1;
         data_d = in_data;
         rd_d   = in_rd;
      end else if (pop) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of block ordering.
      if (rst) begin
         full_q <= 1'b0;
      end else begin
         full_q <= full_d;
      end
   end

   // NOTE: the payload is not reset; it is only observed while full_q is set,
   // and full_q is reset, so a reset on the wide data path buys nothing.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      rd_q   <= rd_d;
   end

   assign full = full_q;
   assign data = data_q;
   assign rd   = rd_q;

endmodule : wb_hold_slot

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Shares the register-file write port between the ALU result and the load
// return path. Each source has a one-entry holding slot; one winner per cycle
// is moved into a registered output stage feeding writebackmux and the
// register-file write enable/address.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   alu_valid/alu_ready, alu_data/rd  ALU result handshake and payload
//   ld_valid/ld_ready,   ld_data/rd   load return handshake and payload
//   wb_data1 / wb_data2               ALU / load lane to writebackmux
//   wb_sel                            mux select (0 = ALU, 1 = load)
//   wb_en, wb_rd                      register-file write enable and address
//
// Optional feature macro: WB_STARVE_GUARD_EN
//   defined   - a pending ALU result that has lost MAX_WAIT times in a row is
//               forced through ahead of the load.
//   undefined - strict load priority, no wait counter.
// -----------------------------------------------------------------------------
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W   = WB_DATA_W,
   parameter int REG_AW   = WB_REG_AW,
   parameter int MAX_WAIT = WB_MAX_WAIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [DATA_W-1:0] alu_data,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [REG_AW-1:0] ld_rd,
   output logic [DATA_W-1:0] wb_data1,
   output logic [DATA_W-1:0] wb_data2,
   output logic              wb_sel,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_rd
);

   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("writeback_arbiter: MAX_WAIT must be in 1..15");
   end

   logic              alu_full, ld_full;
   logic              alu_grant, ld_grant, alu_force;
   logic [DATA_W-1:0] alu_slot_data, ld_slot_data;
   logic [REG_AW-1:0] alu_slot_rd, ld_slot_rd;

   wb_hold_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_alu_slot (
      .clk      (clk),
      .rst      (rst),
      .in_valid (alu_valid),
      .in_ready (alu_ready),
      .in_data  (alu_data),
      .in_rd    (alu_rd),
      .pop      (alu_grant),
      .full     (alu_full),
      .data     (alu_slot_data),
      .rd       (alu_slot_rd)
   );

   wb_hold_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_ld_slot (
      .clk      (clk),
      .rst      (rst),
      .in_valid (ld_valid),
      .in_ready (ld_ready),
      .in_data  (ld_data),
      .in_rd    (ld_rd),
      .pop      (ld_grant),
      .full     (ld_full),
      .data     (ld_slot_data),
      .rd       (ld_slot_rd)
   );

`ifdef WB_STARVE_GUARD_EN
   logic [3:0] alu_wait_q, alu_wait_d;

   assign alu_force = alu_full && ld_full && (alu_wait_q == 4'(MAX_WAIT));

   // Counts consecutive losses of a pending ALU item; saturates at MAX_WAIT.
   always_comb begin
      alu_wait_d = alu_wait_q;
      if (!alu_full || alu_grant) begin
         alu_wait_d = '0;
      end else if (alu_wait_q != 4'(MAX_WAIT)) begin
         alu_wait_d = alu_wait_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_wait_q <= '0;
      end else begin
         alu_wait_q <= alu_wait_d;
      end
   end
`else
   assign alu_force = 1'b0;
`endif

   // Load wins whenever present unless the ALU is being forced through.
   assign ld_grant  = ld_full && !alu_force;
   assign alu_grant = alu_full && !ld_grant;

   logic [DATA_W-1:0] wb_data1_q, wb_data1_d;
   logic [DATA_W-1:0] wb_data2_q, wb_data2_d;
   wb_src_e           wb_sel_q,   wb_sel_d;
   logic              wb_en_q,    wb_en_d;
   logic [REG_AW-1:0] wb_rd_q,    wb_rd_d;

   // Only the granted lane updates; the other lane keeps its last value.
   // A granted item addressed to x0 is consumed without a write enable.
   always_comb begin
      wb_data1_d = wb_data1_q;
      wb_data2_d = wb_data2_q;
      wb_sel_d   = wb_sel_q;
      wb_rd_d    = wb_rd_q;
      wb_en_d    = 1'b0;
      if (ld_grant) begin
         wb_data2_d = ld_slot_data;
         wb_sel_d   = WB_SRC_LD;
         wb_rd_d    = ld_slot_rd;
         wb_en_d    = |ld_slot_rd;
      end else if (alu_grant) begin
         wb_data1_d = alu_slot_data;
         wb_sel_d   = WB_SRC_ALU;
         wb_rd_d    = alu_slot_rd;
         wb_en_d    = |alu_slot_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_data1_q <= '0;
         wb_data2_q <= '0;
         wb_sel_q   <= WB_SRC_ALU;
         wb_en_q    <= 1'b0;
         wb_rd_q    <= '0;
      end else begin
         wb_data1_q <= wb_data1_d;
         wb_data2_q <= wb_data2_d;
         wb_sel_q   <= wb_sel_d;
         wb_en_q    <= wb_en_d;
         wb_rd_q    <= wb_rd_d;
      end
   end

   assign wb_data1 = wb_data1_q;
   assign wb_data2 = wb_data2_q;
   assign wb_sel   = wb_sel_q;
   assign wb_en    = wb_en_q;
   assign wb_rd    = wb_rd_q;

endmodule : writeback_arbiter

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
// Self-checking bench for writeback_arbiter. A queue-based reference model of
// the two pending sources predicts readies and the registered write port every
// cycle; directed scenarios add explicit checks on top of it.
// Honours WB_STARVE_GUARD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int MW = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [AW-1:0] rd;
   } item_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          alu_valid = 1'b0, ld_valid = 1'b0;
   logic [DW-1:0] alu_data = '0, ld_data = '0;
   logic [AW-1:0] alu_rd = '0, ld_rd = '0;
   logic          alu_ready, ld_ready;
   logic [DW-1:0] wb_data1, wb_data2;
   logic          wb_sel, wb_en;
   logic [AW-1:0] wb_rd;

   writeback_arbiter #(.DATA_W(DW), .REG_AW(AW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data), .alu_rd(alu_rd),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_rd(ld_rd),
      .wb_data1(wb_data1), .wb_data2(wb_data2), .wb_sel(wb_sel), .wb_en(wb_en), .wb_rd(wb_rd)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: pending items per source plus the expected write port.
   item_t         m_alu[$];
   item_t         m_ld[$];
   int            m_wait = 0;
   logic          e_en = 0, e_sel = 0;
   logic [AW-1:0] e_rd = 0;
   logic [DW-1:0] e_d1 = 0, e_d2 = 0;
   logic          last_alu_ready, last_ld_ready;

   // 0 = nobody, 1 = ALU, 2 = load
   function automatic int model_winner();
      if (m_alu.size() == 0 && m_ld.size() == 0) return 0;
      if (m_ld.size() == 0) return 1;
      if (m_alu.size() == 0) return 2;
`ifdef WB_STARVE_GUARD_EN
      if (m_wait == MW) return 1;
`endif
      return 2;
   endfunction

   // One clock of stimulus: readies checked mid-cycle, write port after edge.
   task automatic step();
      int    win;
      logic  ar, lr;
      item_t it;
      @(negedge clk);
      win = model_winner();
      ar  = !rst && (m_alu.size() == 0 || win == 1);
      lr  = !rst && (m_ld.size() == 0 || win == 2);
      last_alu_ready = alu_ready;
      last_ld_ready  = ld_ready;
      checks += 2;
      if (alu_ready !== ar) begin failures++; $display("FAIL alu_ready t=%0t got %b want %b", $time, alu_ready, ar); end
      if (ld_ready !== lr) begin failures++; $display("FAIL ld_ready t=%0t got %b want %b", $time, ld_ready, lr); end
      @(posedge clk);
      if (rst) begin
         m_alu.delete(); m_ld.delete(); m_wait = 0;
         e_en = 0; e_sel = 0; e_rd = 0; e_d1 = 0; e_d2 = 0;
      end else begin
         if (m_alu.size() != 0 && win != 1) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
         else m_wait = 0;
         e_en = 0;
         if (win == 2) begin
            it = m_ld.pop_front(); e_sel = 1; e_d2 = it.data; e_rd = it.rd; e_en = (it.rd != 0);
         end else if (win == 1) begin
            it = m_alu.pop_front(); e_sel = 0; e_d1 = it.data; e_rd = it.rd; e_en = (it.rd != 0);
         end
         if (alu_valid && ar) m_alu.push_back(item_t'{data: alu_data, rd: alu_rd});
         if (ld_valid && lr) m_ld.push_back(item_t'{data: ld_data, rd: ld_rd});
      end
      #1;
      checks += 5;
      if (wb_en !== e_en) begin failures++; $display("FAIL wb_en t=%0t got %b want %b", $time, wb_en, e_en); end
      if (wb_sel !== e_sel) begin failures++; $display("FAIL wb_sel t=%0t got %b want %b", $time, wb_sel, e_sel); end
      if (wb_rd !== e_rd) begin failures++; $display("FAIL wb_rd t=%0t got %0d want %0d", $time, wb_rd, e_rd); end
      if (wb_data1 !== e_d1) begin failures++; $display("FAIL wb_data1 t=%0t got %h want %h", $time, wb_data1, e_d1); end
      if (wb_data2 !== e_d2) begin failures++; $display("FAIL wb_data2 t=%0t got %h want %h", $time, wb_data2, e_d2); end
   endtask

   task automatic idle(input int n);
      alu_valid = 0; ld_valid = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      rst = 1;
      for (int i = 0; i < 3; i++) step();
      rst = 0;
      alu_valid = 1; alu_data = 32'hA5; alu_rd = 2;
      ld_valid = 1; ld_data = 32'h5A; ld_rd = 6;
      step();
      checks += 2;
      if (last_alu_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got %b want 1", last_alu_ready); end
      if (wb_en !== 1'b0) begin failures++; $display("FAIL rst_release_en got %b want 0", wb_en); end
      step();
      // Assert reset for two cycles while traffic is still pending.
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks += 4;
         if (last_alu_ready !== 1'b0 || last_ld_ready !== 1'b0) begin
            failures++; $display("FAIL rst_ready got %b%b want 00", last_alu_ready, last_ld_ready);
         end
         if (wb_en !== 1'b0 || wb_sel !== 1'b0) begin failures++; $display("FAIL rst_en_sel got %b%b want 00", wb_en, wb_sel); end
         if (wb_rd !== '0) begin failures++; $display("FAIL rst_rd got %0d want 0", wb_rd); end
         if (wb_data1 !== '0 || wb_data2 !== '0) begin failures++; $display("FAIL rst_data got %h/%h want 0/0", wb_data1, wb_data2); end
      end
      rst = 0;
      idle(1);
      checks += 2;
      if (last_alu_ready !== 1'b1 || last_ld_ready !== 1'b1) begin
         failures++; $display("FAIL post_rst_ready got %b%b want 11", last_alu_ready, last_ld_ready);
      end
      if (wb_en !== 1'b0) begin failures++; $display("FAIL post_rst_spurious_en got %b want 0", wb_en); end
      idle(2);
   endtask

   task automatic test_single_alu();
      alu_valid = 1; alu_data = 32'h1; alu_rd = 5;
      step();
      alu_valid = 0;
      step();
      checks++;
      if (!(wb_en === 1 && wb_sel === 0 && wb_data1 === 32'h1 && wb_rd === 5)) begin
         failures++; $display("FAIL single_alu got en=%b sel=%b d1=%h rd=%0d want 1/0/1/5", wb_en, wb_sel, wb_data1, wb_rd);
      end
      step();
      checks++;
      if (wb_en !== 1'b0) begin failures++; $display("FAIL single_alu_one_cycle got %b want 0", wb_en); end
      idle(1);
   endtask

   task automatic test_collision();
      alu_valid = 1; alu_data = 32'h1; alu_rd = 3;
      ld_valid = 1; ld_data = 32'h2; ld_rd = 4;
      step();
      alu_valid = 0; ld_valid = 0;
      step();
      checks++;
      if (!(wb_en === 1 && wb_sel === 1 && wb_data2 === 32'h2 && wb_rd === 4)) begin
         failures++; $display("FAIL collision_ld_first got en=%b sel=%b d2=%h rd=%0d want 1/1/2/4", wb_en, wb_sel, wb_data2, wb_rd);
      end
      step();
      checks++;
      if (!(wb_en === 1 && wb_sel === 0 && wb_data1 === 32'h1 && wb_rd === 3 && wb_data2 === 32'h2)) begin
         failures++; $display("FAIL collision_alu_second got en=%b sel=%b d1=%h d2=%h rd=%0d want 1/0/1/2/3", wb_en, wb_sel, wb_data1, wb_data2, wb_rd);
      end
      idle(1);
   endtask

   task automatic test_x0_drop();
      ld_valid = 1; ld_data = 32'hDEAD; ld_rd = 0;
      step();
      ld_data = 32'h5; ld_rd = 9;
      step();
      checks += 2;
      if (last_ld_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got %b want 1", last_ld_ready); end
      if (wb_en !== 1'b0) begin failures++; $display("FAIL x0_no_write got %b want 0", wb_en); end
      ld_valid = 0;
      step();
      checks++;
      if (!(wb_en === 1 && wb_sel === 1 && wb_data2 === 32'h5 && wb_rd === 9)) begin
         failures++; $display("FAIL x0_next_load got en=%b d2=%h rd=%0d want 1/5/9", wb_en, wb_data2, wb_rd);
      end
      idle(1);
   endtask

   task automatic test_starvation();
      int n = -1;
      int alu_writes = 0;
      ld_valid = 1; ld_data = $urandom; ld_rd = 1;
      step();
      alu_valid = 1; alu_data = 32'hCAFE; alu_rd = 7;
      step();
      alu_valid = 0;
      for (int i = 1; i <= 14; i++) begin
         ld_data = $urandom; ld_rd = AW'(1 + (i % 6));
         step();
         if (wb_en === 1 && wb_sel === 0) begin
            alu_writes++;
            if (n < 0) n = i;
         end
      end
`ifdef WB_STARVE_GUARD_EN
      checks += 2;
      if (n !== MW + 1) begin failures++; $display("FAIL starve_latency got %0d want %0d", n, MW + 1); end
      if (alu_writes !== 1) begin failures++; $display("FAIL starve_count got %0d want 1", alu_writes); end
`else
      checks++;
      if (alu_writes !== 0) begin failures++; $display("FAIL strict_priority got %0d want 0", alu_writes); end
      ld_valid = 0;
      n = -1;
      for (int i = 1; i <= 4; i++) begin
         step();
         if (n < 0 && wb_en === 1 && wb_sel === 0 && wb_data1 === 32'hCAFE) n = i;
      end
      checks++;
      if (n !== 2) begin failures++; $display("FAIL strict_drain got %0d want 2", n); end
`endif
      idle(2);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i <= 8; i++) begin
         alu_valid = (i < 8); alu_data = 32'h100 + i; alu_rd = AW'(i + 1);
         step();
         if (i < 8) begin
            checks++;
            if (last_alu_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready item %0d got %b want 1", i, last_alu_ready); end
         end
         if (i >= 1) begin
            checks++;
            if (!(wb_en === 1 && wb_data1 === 32'h100 + i - 1 && wb_rd === AW'(i))) begin
               failures++; $display("FAIL b2b_write %0d got en=%b d1=%h rd=%0d", i - 1, wb_en, wb_data1, wb_rd);
            end
         end
      end
      idle(2);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         alu_valid = ($urandom_range(0, 9) < 6);
         ld_valid  = ($urandom_range(0, 9) < 6);
         alu_data = $urandom; alu_rd = AW'($urandom_range(0, 7));
         ld_data  = $urandom; ld_rd  = AW'($urandom_range(0, 7));
         step();
      end
      idle(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_alu();
      test_collision();
      test_x0_drop();
      test_starvation();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_writeback_arbiter
